// File: rtl/fnd_scan_ctrl_n.sv
// N-digit 7-segment scan controller with sequential binary-to-BCD loader.
// Ports: clk/reset, load_valid/ready/value, dot/blink masks, blank_lz, fnd_digit/data, overflow.
module fnd_scan_ctrl_n #(
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 14,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int BLINK_HZ = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [DATA_W-1:0]   load_value,
  input  logic [N_DIGITS-1:0] dot_mask,
  input  logic [N_DIGITS-1:0] blink_mask,
  input  logic                blank_lz,
  output logic [N_DIGITS-1:0] fnd_digit,
  output logic [7:0]          fnd_data,
  output logic                overflow
);

  localparam int BW        = 4 * N_DIGITS;
  localparam int SCAN_MAX  = CLK_HZ / SCAN_HZ - 1;
  localparam int BLINK_MAX = CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int TW        = $clog2(SCAN_MAX + 2);
  localparam int PW        = $clog2(BLINK_MAX + 2);
  localparam int IW        = $clog2(N_DIGITS);
  localparam int CW        = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = 64'(10 ** N_DIGITS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [DATA_W-1:0]    bin;
  logic [BW-1:0]        bcd;
  logic [BW-1:0]        adj;
  logic [BW+DATA_W-1:0] shifted;
  logic [BW-1:0]        disp;
  logic                 ovf_pend;
  logic                 accept;

  logic [TW-1:0]        tick;
  logic [IW-1:0]        idx;
  logic [PW-1:0]        bcnt;
  logic                 phase;

  assign load_ready = (state == IDLE);
  assign accept     = load_valid & load_ready;

  always_comb begin
    adj = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  // Digits above N_DIGITS fall off the top of the shift.
  assign shifted = {adj, bin} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bin      <= '0;
      bcd      <= '0;
      disp     <= '0;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bin      <= load_value;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= (64'(load_value) >= LIMIT);
            state    <= CONV;
          end
        end
        CONV: begin
          bin <= shifted[DATA_W-1:0];
          bcd <= shifted[BW+DATA_W-1:DATA_W];
          if (cnt == CW'(DATA_W - 1))
            state <= COMMIT;
          else
            cnt <= cnt + 1'b1;
        end
        COMMIT: begin
          disp     <= bcd;
          overflow <= ovf_pend;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TW'(SCAN_MAX)) begin
      tick <= '0;
      if (idx == IW'(N_DIGITS - 1))
        idx <= '0;
      else
        idx <= idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == PW'(BLINK_MAX)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign fnd_digit = ~(N_DIGITS'(1) << idx);

  // zup[i]: digit i and everything above it are zero.
  logic [N_DIGITS-1:0] zup;
  always_comb begin
    zup = '0;
    for (int i = 0; i < N_DIGITS; i++)
      zup[i] = ((disp >> (4 * i)) == '0);
  end

  logic [3:0] nib;
  logic       dm;
  logic       bm;
  logic       zu;
  logic [7:0] dec;
  logic [7:0] base;

  always_comb begin
    nib = '0;
    dm  = 1'b0;
    bm  = 1'b0;
    zu  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib = disp[4*i +: 4];
        dm  = dot_mask[i];
        bm  = blink_mask[i];
        zu  = zup[i];
      end
    end
  end

  always_comb begin
    case (nib)
      4'd0:    dec = 8'hC0;
      4'd1:    dec = 8'hF9;
      4'd2:    dec = 8'hA4;
      4'd3:    dec = 8'hB0;
      4'd4:    dec = 8'h99;
      4'd5:    dec = 8'h92;
      4'd6:    dec = 8'h82;
      4'd7:    dec = 8'hF8;
      4'd8:    dec = 8'h80;
      4'd9:    dec = 8'h90;
      default: dec = 8'hFF;
    endcase
  end

  always_comb begin
    base     = dec;
    fnd_data = 8'hFF;
    if (overflow)
      base = 8'hBF;
    else if (blank_lz && (idx != '0) && zu)
      base = 8'hFF;
    // Blink blanking wins outright, including over the dot.
    if (!(bm && !phase))
      fnd_data = {base[7] & ~dm, base[6:0]};
  end

endmodule

// File: tb/tb_fnd_scan_ctrl_n.sv
// Testbench for fnd_scan_ctrl_n: directed loads, scoreboard of committed values.
// Checks handshake latency, scan order, blanking, overflow, reset abort and blink.
module tb_fnd_scan_ctrl_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [13:0] load_value = '0;
  logic [3:0]  dot_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  fnd_digit;
  logic [7:0]  fnd_data;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  int sb[$];
  int committed = 0;
  int tb_cyc;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_scan_ctrl_n #(
    .N_DIGITS(4), .DATA_W(14), .CLK_HZ(100),
    .SCAN_HZ(10), .BLINK_HZ(1)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .dot_mask(dot_mask),
    .blink_mask(blink_mask), .blank_lz(blank_lz),
    .fnd_digit(fnd_digit), .fnd_data(fnd_data),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int v, input int i);
    logic [7:0] s;
    int p10 = 1;
    for (int k = 0; k < i; k++) p10 *= 10;
    if (blink_mask[i] && ((tb_cyc / 50) % 2) == 1) return 8'hFF;
    if (v >= 10000)                       s = 8'hBF;
    else if (blank_lz && i > 0 && v < p10) s = 8'hFF;
    else                                  s = seg_tbl[(v / p10) % 10];
    if (dot_mask[i]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic wait_digit(input int i);
    logic [3:0] want;
    int c = 0;
    want = ~(4'(1) << i);
    while (fnd_digit !== want && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("digit_sel", fnd_digit, want);
  endtask

  task automatic check_display(input string tag);
    for (int i = 0; i < 4; i++) begin
      wait_digit(i);
      check(tag, fnd_data, exp_seg(committed, i));
    end
  endtask

  task automatic do_load(input int v);
    int c = 0;
    @(negedge clk);
    load_value = 14'(v);
    load_valid = 1'b1;
    while (!load_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("accept_wait", 32'(c < 200), 32'd1);
    sb.push_back(v);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic wait_commit(input int exp_low);
    int c = 0;
    int v;
    @(negedge clk);
    while (!load_ready && c < 200) begin
      c++;
      @(negedge clk);
    end
    check("ready_low", c, exp_low);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      v = sb.pop_front();
      committed = v;
      check("overflow", overflow, 32'(v >= 10000));
    end
  endtask

  initial begin
    int seen_ff;
    int seen_on;

    // reset state, including dot on digit 0
    dot_mask = 4'b0001;
    #12;
    check("rst_data_dot", fnd_data, 8'h40);
    dot_mask = 4'b0000;
    #1;
    check("rst_data", fnd_data, 8'hC0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", load_ready, 1'b1);
    check("rst_ovf", overflow, 1'b0);
    check("rst_digit", fnd_digit, 4'b1110);

    // scan timing
    repeat (9) @(negedge clk);
    check("scan_9", fnd_digit, 4'b1110);
    @(negedge clk);
    check("scan_10", fnd_digit, 4'b1101);
    repeat (30) @(negedge clk);
    check("scan_40", fnd_digit, 4'b1110);

    // 1234, with a dot on digit 2
    do_load(1234);
    wait_commit(15);
    check_display("d1234");
    dot_mask = 4'b0100;
    check_display("d1234_dot");
    dot_mask = 4'b0000;

    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(7);
    wait_commit(15);
    check_display("d7_lz");
    blank_lz = 1'b0;
    check_display("d7_nolz");
    blank_lz = 1'b1;
    do_load(0);
    wait_commit(15);
    check_display("d0_lz");

    // overflow, then clear
    do_load(10000);
    wait_commit(15);
    check_display("ovf");
    do_load(9999);
    wait_commit(15);
    check_display("d9999");

    // load during conversion is ignored
    do_load(1234);
    @(negedge clk);
    @(negedge clk);
    load_value = 14'd5;
    load_valid = 1'b1;
    check("busy_ready", load_ready, 1'b0);
    @(negedge clk);
    load_valid = 1'b0;
    wait_commit(12);
    for (int i = 0; i < 4; i++)
      if (fnd_digit == ~(4'(1) << i))
        check("d1234_now", fnd_data, exp_seg(committed, i));
    do_load(5);
    wait_commit(15);
    check_display("d5_lz");

    // reset mid-conversion aborts
    do_load(4321);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #2;
    check("abort_ready", load_ready, 1'b1);
    check("abort_data", fnd_data, 8'hC0);
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    committed = 0;
    blank_lz = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle", load_ready, 1'b1);
    check("abort_ovf", overflow, 1'b0);
    check_display("abort_disp");

    // blink on digit 0, dot ignored while blanked
    dot_mask = 4'b0001;
    blink_mask = 4'b0001;
    seen_ff = 0;
    seen_on = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (fnd_digit == 4'b1110) begin
        check("blink", fnd_data, exp_seg(0, 0));
        if (fnd_data == 8'hFF) seen_ff++;
        if (fnd_data == 8'h40) seen_on++;
      end
    end
    check("blink_off_seen", 32'(seen_ff > 0), 32'd1);
    check("blink_on_seen", 32'(seen_on > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
